// File: rtl/tinker_mem_pkg.sv
// Shared types and widths for the tinker memory-port arbiter.
package tinker_mem_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  localparam int INSTR_W = 32;
  localparam int DATA_W  = 64;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tinker_mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter.
// slave: the arbiter's view. master: the environment (fetch, data path, memory).
interface tinker_mem_arbiter_if #(
  parameter int ADDR_W = 64
);
  import tinker_mem_pkg::*;

  logic               if_req_valid;
  logic               if_req_ready;
  logic [ADDR_W-1:0]  if_addr;
  logic               if_rsp_valid;
  logic [INSTR_W-1:0] if_rsp_data;

  logic               d_req_valid;
  logic               d_req_ready;
  logic               d_req_we;
  logic [ADDR_W-1:0]  d_addr;
  logic [DATA_W-1:0]  d_wdata;
  logic               d_rsp_valid;
  logic [DATA_W-1:0]  d_rsp_data;

  logic               mem_req_valid;
  logic               mem_req_ready;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic               mem_rsp_valid;
  logic [DATA_W-1:0]  mem_rsp_data;

  logic               err;

  modport slave (
    input  if_req_valid, if_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  d_req_valid, d_req_we, d_addr, d_wdata,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output mem_req_valid, mem_we, mem_addr, mem_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output err
  );

  modport master (
    output if_req_valid, if_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output d_req_valid, d_req_we, d_addr, d_wdata,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  err
  );

endinterface

// File: rtl/tinker_starve_ctr.sv
// Saturating count of consecutive data grants taken while fetch was waiting.
module tinker_starve_ctr
  import tinker_mem_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CNT_W = cnt_width(LIMIT);

  logic [CNT_W-1:0] cnt;

  assign sat = (cnt == CNT_W'(LIMIT));

  // Clear has priority; increment stops at the limit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tinker_mem_arbiter.sv
// Shares the single tinker memory port between instruction fetch and the data path.
// One transaction in flight; data wins unless fetch has been starved STARVE_LIMIT times.
//
//   state | meaning
//   IDLE  | ready offered to the arbitration winner; accept latches the request
//   ISSUE | mem_req_valid held until the memory takes it
//   WAIT  | waiting for the single response; timeout counter running
//   ERR   | response timed out; port frozen until reset
module tinker_mem_arbiter
  import tinker_mem_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int RSP_TIMEOUT  = 255
) (
  input logic                 clock,
  input logic                 reset,
  tinker_mem_arbiter_if.slave bus
);

  localparam int WAIT_W = cnt_width(RSP_TIMEOUT);

  arb_state_t         state;
  owner_t             owner;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               err_q;
  logic               mem_req_valid_q;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  logic               if_rsp_valid_q;
  logic [INSTR_W-1:0] if_rsp_data_q;
  logic               d_rsp_valid_q;
  logic [DATA_W-1:0]  d_rsp_data_q;

  logic in_idle, fetch_win, if_acc, d_acc;
  logic starve_sat, starve_inc, starve_clr, timeout_hit;

  assign in_idle   = (state == IDLE);
  assign fetch_win = bus.if_req_valid && (!bus.d_req_valid || starve_sat);
  assign if_acc    = in_idle && fetch_win;
  assign d_acc     = in_idle && bus.d_req_valid && !fetch_win;

  // A data grant while fetch waits counts as starvation; fetch grant or fetch idle resets it.
  assign starve_inc = d_acc && bus.if_req_valid;
  assign starve_clr = if_acc || (in_idle && !bus.if_req_valid);

  // wait_cnt counts completed WAIT cycles, so the last allowed cycle sees RSP_TIMEOUT-1.
  assign timeout_hit = (RSP_TIMEOUT != 0) && (wait_cnt == WAIT_W'(RSP_TIMEOUT - 1));

  tinker_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clock(clock),
    .reset(reset),
    .inc  (starve_inc),
    .clr  (starve_clr),
    .sat  (starve_sat)
  );

  // Arbitration FSM with request, response and timeout registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      owner           <= OWN_IF;
      wait_cnt        <= '0;
      err_q           <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      if_rsp_valid_q  <= 1'b0;
      if_rsp_data_q   <= '0;
      d_rsp_valid_q   <= 1'b0;
      d_rsp_data_q    <= '0;
    end else begin
      if_rsp_valid_q <= 1'b0;
      d_rsp_valid_q  <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (if_acc) begin
            owner           <= OWN_IF;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= bus.if_addr;
            mem_wdata_q     <= '0;
            mem_req_valid_q <= 1'b1;
            state           <= ISSUE;
          end else if (d_acc) begin
            owner           <= OWN_D;
            mem_we_q        <= bus.d_req_we;
            mem_addr_q      <= bus.d_addr;
            mem_wdata_q     <= bus.d_wdata;
            mem_req_valid_q <= 1'b1;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state           <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rsp_valid) begin
            if (owner == OWN_IF) begin
              if_rsp_valid_q <= 1'b1;
              if_rsp_data_q  <= bus.mem_rsp_data[INSTR_W-1:0];
            end else begin
              d_rsp_valid_q <= 1'b1;
              d_rsp_data_q  <= mem_we_q ? '0 : bus.mem_rsp_data;
            end
            wait_cnt <= '0;
            state    <= IDLE;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            state <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.if_req_ready  = if_acc;
  assign bus.d_req_ready   = d_acc;
  assign bus.if_rsp_valid  = if_rsp_valid_q;
  assign bus.if_rsp_data   = if_rsp_data_q;
  assign bus.d_rsp_valid   = d_rsp_valid_q;
  assign bus.d_rsp_data    = d_rsp_data_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.err           = err_q;

endmodule
